// File: rtl/bdd_node_walker.sv
// Decision-tree walker: fetches node words, requests a MAC per internal node, follows children to a leaf.
// Optional BDD_WALK_PATH_EN records the left/right decision history in path_bits.
module bdd_node_walker #(
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 20,
  parameter int CLASS_W   = 4,
  parameter int MAX_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   root_addr,
  output logic                                node_rd_en,
  output logic [ADDR_W-1:0]                   node_rd_addr,
  input  logic [1+ACC_W+2*ADDR_W+CLASS_W-1:0] node_rd_data,
  output logic                                mac_start,
  output logic [ADDR_W-1:0]                   mac_node,
  input  logic [ACC_W-1:0]                    acc,
  input  logic                                acc_valid,
  output logic                                busy,
  output logic                                done,
  output logic [CLASS_W-1:0]                  class_out,
  output logic                                err,
  output logic [MAX_DEPTH-1:0]                path_bits
);

  localparam int NODE_W  = 1 + ACC_W + 2*ADDR_W + CLASS_W;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_CHECK, S_MAC_REQ, S_WAIT_MAC, S_DECIDE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  cur;
  logic [DEPTH_W-1:0] depth;
  logic [ACC_W-1:0]   thr_q;
  logic [ADDR_W-1:0]  left_q, right_q;
  logic               dec;

  logic               rd_leaf;
  logic [ACC_W-1:0]   rd_thr;
  logic [ADDR_W-1:0]  rd_left, rd_right;
  logic [CLASS_W-1:0] rd_class;

  assign rd_leaf  = node_rd_data[NODE_W-1];
  assign rd_thr   = node_rd_data[NODE_W-2 -: ACC_W];
  assign rd_left  = node_rd_data[2*ADDR_W+CLASS_W-1 -: ADDR_W];
  assign rd_right = node_rd_data[ADDR_W+CLASS_W-1 -: ADDR_W];
  assign rd_class = node_rd_data[CLASS_W-1:0];

  // cur only moves in DECIDE, so it doubles as the stable MAC node index.
  assign node_rd_en   = (state == S_FETCH);
  assign node_rd_addr = cur;
  assign mac_start    = (state == S_MAC_REQ);
  assign mac_node     = cur;
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_WAIT_MEM;
      S_WAIT_MEM: state_nxt = S_CHECK;
      S_CHECK:    state_nxt = done ? S_IDLE : S_MAC_REQ;
      S_MAC_REQ:  state_nxt = S_WAIT_MAC;
      S_WAIT_MAC: if (acc_valid) state_nxt = S_DECIDE;
      S_DECIDE:   state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Leaf/depth outcome is resolved as the node word lands, so done is a registered pulse during CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      depth     <= '0;
      thr_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      dec       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      class_out <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cur   <= root_addr;
          depth <= '0;
          err   <= 1'b0;
        end
        S_WAIT_MEM: begin
          thr_q   <= rd_thr;
          left_q  <= rd_left;
          right_q <= rd_right;
          if (rd_leaf) begin
            class_out <= rd_class;
            done      <= 1'b1;
          end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
            err  <= 1'b1;
            done <= 1'b1;
          end
        end
        S_WAIT_MAC: if (acc_valid) dec <= (acc >= thr_q);
        S_DECIDE: begin
          cur   <= dec ? right_q : left_q;
          depth <= depth + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BDD_WALK_PATH_EN
  logic [MAX_DEPTH-1:0] path_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      path_q <= '0;
    end else if (state == S_IDLE && start) begin
      path_q <= '0;
    end else if (state == S_DECIDE) begin
      for (int i = 0; i < MAX_DEPTH; i++)
        if (depth == DEPTH_W'(i)) path_q[i] <= dec;
    end
  end

  assign path_bits = path_q;
`else
  assign path_bits = '0;
`endif

endmodule

// File: tb/tb_bdd_node_walker.sv
// Randomized self-checking bench for bdd_node_walker with node RAM and MAC responders and a tree-walk reference model.
module tb_bdd_node_walker;
  localparam int MAX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  root_addr = '0;
  logic        node_rd_en;
  logic [7:0]  node_rd_addr;
  logic [40:0] node_rd_data = '0;
  logic        mac_start;
  logic [7:0]  mac_node;
  logic [19:0] acc = '0;
  logic        acc_valid = 1'b0;
  logic        busy, done, err;
  logic [3:0]  class_out;
  logic [15:0] path_bits;

  always #5 clk = ~clk;

  bdd_node_walker dut (
    .clk(clk), .rst(rst), .start(start), .root_addr(root_addr),
    .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr), .node_rd_data(node_rd_data),
    .mac_start(mac_start), .mac_node(mac_node), .acc(acc), .acc_valid(acc_valid),
    .busy(busy), .done(done), .class_out(class_out), .err(err), .path_bits(path_bits)
  );

  logic [40:0] mem     [256];
  logic [19:0] mac_val [256];
  int          n_cmp = 0, n_fail = 0;
  int          mac_cnt = 0, w_sum = 0, fixed_w = 0;
  int          stray_pend = 0, stray_ack = 0;
  bit          mac_auto = 1'b1;
  logic [7:0]  last_mac_node = '0;
  logic [3:0]  exp_class = '0;

  // Node RAM: data appears one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin : ram_model
    logic [63:0] g;
    g = {$urandom, $urandom};
    node_rd_data <= node_rd_en ? mem[node_rd_addr] : g[40:0];
  end

  always @(negedge clk) if (mac_start) mac_cnt++;

  // MAC: answers mac_val[node] W cycles after mac_start; also emits stray pulses on request.
  always begin : mac_model
    int w;
    logic [63:0] g;
    @(negedge clk);
    if (mac_start && mac_auto) begin
      last_mac_node = mac_node;
      w = (fixed_w > 0) ? fixed_w : int'($urandom_range(1, 4));
      w_sum += w;
      repeat (w) @(negedge clk);
      acc = mac_val[last_mac_node];
      acc_valid = 1'b1;
      @(negedge clk);
      acc_valid = 1'b0;
      g = {$urandom, $urandom};
      acc = g[19:0];
    end else if (stray_ack != stray_pend) begin
      stray_ack = stray_pend;
      acc = 20'h00000;
      acc_valid = 1'b1;
      @(negedge clk);
      acc_valid = 1'b0;
    end
  end

  function automatic logic [40:0] mk(input logic leaf, input logic [19:0] thr,
                                     input logic [7:0] l, input logic [7:0] r, input logic [3:0] c);
    return {leaf, thr, l, r, c};
  endfunction

  // Reference: walk the tree in memory with plain decisions; n = internal nodes visited.
  task automatic model_walk(input logic [7:0] root, output logic [3:0] cls, output logic e,
                            output logic [15:0] path, output int n);
    logic [7:0]  cur;
    logic [40:0] w;
    logic        dec;
    int          d;
    cur = root; d = 0; path = '0; cls = exp_class; e = 1'b0;
    forever begin
      w = mem[cur];
      if (w[40]) begin cls = w[3:0]; break; end
      if (d == MAX_DEPTH) begin e = 1'b1; break; end
      dec = (mac_val[cur] >= w[39:20]);
      path[d] = dec;
      cur = dec ? w[11:4] : w[19:12];
      d++;
    end
    n = d;
`ifndef BDD_WALK_PATH_EN
    path = '0;
`endif
  endtask

  // Drives one walk from a negedge; lat counts the start cycle as 1.
  task automatic do_walk(input logic [7:0] root, input int inj, output int lat, output logic to,
                         output logic busy_ok, output logic done_ok, output logic [3:0] cls,
                         output logic e, output logic [15:0] path);
    lat = 1; to = 1'b0; busy_ok = 1'b1; done_ok = 1'b1;
    root_addr = root;
    start = 1'b1;
    forever begin
      @(negedge clk);
      lat++;
      start = (lat == inj);
      if (lat == inj) root_addr = root ^ 8'h5A;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
      if (lat > 3000) begin to = 1'b1; break; end
    end
    cls = class_out; e = err; path = path_bits;
    @(negedge clk);
    start = 1'b0;
    if (done || busy) done_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, node_rd_en, mac_start, class_out, path_bits, node_rd_addr, mac_node} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got b%0b d%0b e%0b class %0d path %h addr %0d", busy, done, err, class_out, path_bits, node_rd_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, node_rd_en, mac_start} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got busy %0b done %0b rd_en %0b mac_start %0b, want all 0", busy, done, node_rd_en, mac_start);
    end
  endtask

  task automatic test_leaf_root();
    int lat, n, mb; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[5] = mk(1, 20'd0, 8'd0, 8'd0, 4'd3);
    model_walk(8'd5, ecls, ee, ep, n);
    mb = mac_cnt;
    do_walk(8'd5, 0, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL leaf_latency: got %0d want 4", lat); end
    n_cmp++; if (cls !== 4'd3 || e !== 1'b0) begin n_fail++; $display("FAIL leaf_result: got class %0d err %0b want 3/0", cls, e); end
    n_cmp++; if (mac_cnt - mb !== 0) begin n_fail++; $display("FAIL leaf_no_mac: got %0d mac_start want 0", mac_cnt - mb); end
    n_cmp++; if (to || !dok) begin n_fail++; $display("FAIL leaf_done_pulse: timeout %0b done_ok %0b", to, dok); end
    exp_class = ecls;
  endtask

  task automatic test_two_level();
    int lat, n; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[0] = mk(0, 20'd100, 8'd1, 8'd2, 4'd0);
    mem[1] = mk(1, 20'd0, 8'd0, 8'd0, 4'd7);
    mem[2] = mk(1, 20'd0, 8'd0, 8'd0, 4'd9);
    mac_val[0] = 20'd100; fixed_w = 1;
    model_walk(8'd0, ecls, ee, ep, n);
    do_walk(8'd0, 0, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (cls !== 4'd9) begin n_fail++; $display("FAIL two_level_class: got %0d want 9", cls); end
    n_cmp++; if (p !== ep) begin n_fail++; $display("FAIL two_level_path: got %h want %h", p, ep); end
    n_cmp++; if (last_mac_node !== 8'd0) begin n_fail++; $display("FAIL two_level_mac_node: got %0d want 0", last_mac_node); end
    n_cmp++; if (lat !== 10 || to) begin n_fail++; $display("FAIL two_level_latency: got %0d want 10", lat); end
    exp_class = ecls;
  endtask

  task automatic test_left_slow();
    int lat, n, mb; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[0] = mk(0, 20'd500, 8'd1, 8'd2, 4'd0);
    mem[1] = mk(1, 20'd0, 8'd0, 8'd0, 4'd6);
    mac_val[0] = 20'd499; fixed_w = 7;
    model_walk(8'd0, ecls, ee, ep, n);
    mb = mac_cnt;
    do_walk(8'd0, 0, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (cls !== 4'd6 || p !== ep) begin n_fail++; $display("FAIL left_slow_result: got class %0d path %h want 6 %h", cls, p, ep); end
    n_cmp++; if (lat !== 16 || to) begin n_fail++; $display("FAIL left_slow_latency: got %0d want 16", lat); end
    n_cmp++; if (!bok) begin n_fail++; $display("FAIL left_slow_busy: busy dropped during walk, want held"); end
    n_cmp++; if (mac_cnt - mb !== 1) begin n_fail++; $display("FAIL left_slow_macs: got %0d want 1", mac_cnt - mb); end
    exp_class = ecls;
  endtask

  task automatic test_depth_limit();
    int lat, n, mb; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[4] = mk(0, 20'd0, 8'd4, 8'd4, 4'd0);
    mac_val[4] = 20'd0; fixed_w = 1;
    model_walk(8'd4, ecls, ee, ep, n);
    mb = mac_cnt;
    do_walk(8'd4, 0, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (mac_cnt - mb !== 16) begin n_fail++; $display("FAIL depth_macs: got %0d want 16", mac_cnt - mb); end
    n_cmp++; if (e !== 1'b1 || cls !== exp_class) begin n_fail++; $display("FAIL depth_err: got err %0b class %0d want 1 %0d", e, cls, exp_class); end
    n_cmp++; if (p !== ep) begin n_fail++; $display("FAIL depth_path: got %h want %h", p, ep); end
    n_cmp++; if (lat !== 100 || to) begin n_fail++; $display("FAIL depth_latency: got %0d want 100", lat); end
    exp_class = ecls;
  endtask

  task automatic test_threshold_edges();
    int lat, n; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[10] = mk(0, 20'hFFFFF, 8'd11, 8'd12, 4'd0);
    mem[11] = mk(1, 20'd0, 8'd0, 8'd0, 4'd1);
    mem[12] = mk(1, 20'd0, 8'd0, 8'd0, 4'd2);
    fixed_w = 2;
    for (int k = 0; k < 2; k++) begin
      mac_val[10] = (k == 0) ? 20'hFFFFE : 20'hFFFFF;
      model_walk(8'd10, ecls, ee, ep, n);
      do_walk(8'd10, 0, lat, to, bok, dok, cls, e, p);
      n_cmp++; if (cls !== ecls || e !== 1'b0) begin n_fail++; $display("FAIL thr_max_%0d: got class %0d err %0b want %0d 0", k, cls, e, ecls); end
      exp_class = ecls;
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, n; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    do_walk(8'd5, 0, lat1, to, bok, dok, cls, e, p);
    exp_class = 4'd3;
    mem[2] = mk(1, 20'd0, 8'd0, 8'd0, 4'd9);
    model_walk(8'd2, ecls, ee, ep, n);
    do_walk(8'd2, 0, lat2, to, bok, dok, cls, e, p);
    n_cmp++; if (lat2 !== 4 || cls !== ecls || to) begin n_fail++; $display("FAIL back_to_back: got lat %0d class %0d want 4 %0d", lat2, cls, ecls); end
    exp_class = ecls;
  endtask

  task automatic test_ignored_inputs();
    int lat, n; logic to, bok, dok, e, ee, seen; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[20] = mk(0, 20'd1000, 8'd21, 8'd22, 4'd0);
    mem[21] = mk(1, 20'd0, 8'd0, 8'd0, 4'd4);
    mem[22] = mk(1, 20'd0, 8'd0, 8'd0, 4'd5);
    mem[20 ^ 8'h5A] = mk(1, 20'd0, 8'd0, 8'd0, 4'd15);
    mac_val[20] = 20'd2000; fixed_w = 2;
    model_walk(8'd20, ecls, ee, ep, n);
    do_walk(8'd20, 3, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (cls !== ecls || lat !== 11 || to) begin n_fail++; $display("FAIL busy_start: got class %0d lat %0d want %0d 11", cls, lat, ecls); end
    exp_class = ecls;
    stray_pend++;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (busy || done) seen = 1'b1; end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL stray_acc_state: got busy/done activity want none"); end
    n_cmp++; if (class_out !== exp_class || err !== 1'b0 || node_rd_addr !== 8'd22) begin
      n_fail++; $display("FAIL stray_acc_outputs: got class %0d err %0b cur %0d want %0d 0 22", class_out, err, node_rd_addr, exp_class);
    end
  endtask

  task automatic test_reset_mid_walk();
    int lat, n; logic to, bok, dok, e, ee, seen; logic [3:0] cls, ecls; logic [15:0] p, ep;
    mem[0] = mk(0, 20'd100, 8'd1, 8'd2, 4'd0);
    mem[1] = mk(1, 20'd0, 8'd0, 8'd0, 4'd7);
    mac_auto = 1'b0;
    root_addr = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !mac_start; i++) @(negedge clk);
    n_cmp++; if (mac_start !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_mac: got mac_start %0b want 1", mac_start); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, err, node_rd_en, mac_start, class_out, path_bits, node_rd_addr, mac_node} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got busy %0b class %0d path %h addr %0d want all 0", busy, class_out, path_bits, node_rd_addr);
    end
    exp_class = 4'd0;
    stray_pend++;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy || done) seen = 1'b1; end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rst_mid_late_acc: got walk activity after reset want none"); end
    mac_auto = 1'b1;
    mac_val[0] = 20'd50; fixed_w = 1;
    model_walk(8'd0, ecls, ee, ep, n);
    do_walk(8'd0, 0, lat, to, bok, dok, cls, e, p);
    n_cmp++; if (cls !== 4'd7 || p !== ep || lat !== 10) begin n_fail++; $display("FAIL rst_mid_rewalk: got class %0d path %h lat %0d want 7 %h 10", cls, p, lat, ep); end
    exp_class = ecls;
  endtask

  task automatic test_random();
    int lat, n, mb, wb; logic to, bok, dok, e, ee; logic [3:0] cls, ecls; logic [15:0] p, ep;
    logic [7:0] root;
    fixed_w = 0;
    for (int it = 0; it < 30; it++) begin
      if (it % 10 == 0) begin
        for (int a = 0; a < 256; a++) begin
          logic [19:0] thr;
          case ($urandom_range(0, 3))
            0: thr = 20'h00000;
            1: thr = 20'hFFFFF;
            default: thr = 20'($urandom);
          endcase
          mem[a] = mk($urandom_range(0, 99) < 35, thr, 8'($urandom), 8'($urandom), 4'($urandom));
          case ($urandom_range(0, 3))
            0: mac_val[a] = thr;
            1: mac_val[a] = 20'hFFFFF;
            default: mac_val[a] = 20'($urandom);
          endcase
        end
      end
      root = 8'($urandom);
      model_walk(root, ecls, ee, ep, n);
      mb = mac_cnt; wb = w_sum;
      do_walk(root, 0, lat, to, bok, dok, cls, e, p);
      n_cmp++;
      if (cls !== ecls || e !== ee || p !== ep) begin
        n_fail++; $display("FAIL rand_%0d_result: got class %0d err %0b path %h want %0d %0b %h", it, cls, e, p, ecls, ee, ep);
      end
      n_cmp++;
      if (lat !== 4 + 5*n + (w_sum - wb) || mac_cnt - mb !== n || to || !bok || !dok) begin
        n_fail++; $display("FAIL rand_%0d_timing: got lat %0d macs %0d want %0d %0d", it, lat, mac_cnt - mb, 4 + 5*n + (w_sum - wb), n);
      end
      exp_class = ecls;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = mk(1, 20'd0, 8'd0, 8'd0, 4'd0);
      mac_val[a] = 20'd0;
    end
    @(negedge clk);
    test_reset();
    test_leaf_root();
    test_two_level();
    test_left_slow();
    test_depth_limit();
    test_threshold_edges();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid_walk();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bdd_node_walker.md
Name: bdd_node_walker

Overview:
- Tree-traversal controller that sits directly downstream of the 20-bit dot-product MAC stage.
- For each node it fetches the node word from node RAM and requests a MAC evaluation for that node.
- It compares the returned accumulator against the node threshold and follows the left or right child until it reaches a leaf.
- It reports the leaf class, or an error if the depth budget is exhausted.

Parameters:
- ADDR_W, 8, node RAM address width and child pointer width.
- ACC_W, 20, MAC accumulator width; must equal the MAC output width.
- CLASS_W, 4, leaf class label width.
- MAX_DEPTH, 16, maximum number of internal nodes visited before an error is flagged (1..32).
- NODE_W (localparam), 1+ACC_W+2*ADDR_W+CLASS_W = 41, node word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a walk; sampled only in IDLE.
- root_addr  in  ADDR_W  address of the root node; captured with start.
- node_rd_en  out  1  node RAM read strobe.
- node_rd_addr  out  ADDR_W  node RAM read address.
- node_rd_data  in  NODE_W  node word; valid exactly 1 cycle after node_rd_en. Field layout from MSB: is_leaf, threshold[ACC_W], left[ADDR_W], right[ADDR_W], class[CLASS_W].
- mac_start  out  1  one-cycle pulse requesting evaluation of node mac_node.
- mac_node  out  ADDR_W  node index for the MAC coefficient fetch; held stable until acc_valid.
- acc  in  ACC_W  MAC result, unsigned.
- acc_valid  in  1  one-cycle pulse qualifying acc.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at walk completion.
- class_out  out  CLASS_W  leaf class; held from done until the next done.
- err  out  1  set together with done when the depth limit is hit; cleared on the next start.
- path_bits  out  MAX_DEPTH  decision history (see Optional Feature).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - state = IDLE
  - node_rd_en, mac_start, done, err, busy = 0
  - class_out, path_bits, node_rd_addr, mac_node = 0
  - depth counter = 0
- Reset asserted mid-walk aborts the walk with no done pulse. Any acc_valid arriving afterwards in IDLE is ignored.
- State machine:
  - IDLE: on start, latch cur = root_addr, depth = 0, err = 0, then go to FETCH. A start pulse in any other state is ignored.
  - FETCH: node_rd_en = 1, node_rd_addr = cur for exactly one cycle, then go to WAIT_MEM.
  - WAIT_MEM: register node_rd_data into the node register, then go to CHECK.
  - CHECK:
    - If is_leaf: class_out = class, done = 1, go to IDLE.
    - Else if depth == MAX_DEPTH: err = 1, done = 1, class_out unchanged, go to IDLE.
    - Else go to MAC_REQ.
  - MAC_REQ: mac_start = 1 for one cycle, mac_node = cur, then go to WAIT_MAC.
  - WAIT_MAC: wait indefinitely for acc_valid. An acc_valid in the same cycle as mac_start (MAC_REQ state) is ignored.
  - DECIDE (entered on the cycle acc_valid is sampled; the decision is registered):
    - If acc >= threshold (unsigned, full ACC_W compare): cur = right, decision bit = 1.
    - Else: cur = left, decision bit = 0.
    - depth += 1, then go to FETCH.
- Latency:
  - Leaf root: start to done = 4 cycles (IDLE→FETCH→WAIT_MEM→CHECK, done asserted on CHECK).
  - Each internal node adds 5 cycles plus the MAC wait, counted from the mac_start cycle to acc_valid.
- Boundary conditions:
  - acc == threshold goes right.
  - threshold = 0 always goes right.
  - threshold = 2^ACC_W-1 goes right only when acc is all-ones.
  - A child pointer equal to the node's own address is legal; the walk terminates via the depth limit with err=1.
  - Child address arithmetic does not wrap; pointers are used verbatim.
  - done and start in the same cycle: start is accepted on the following cycle (state is IDLE after done).

Optional Feature:
- Macro: BDD_WALK_PATH_EN.
- Defined:
  - path_bits is cleared on start.
  - On each DECIDE, the decision bit is written to path_bits[depth].
  - The value is held after done until the next start, so the bench and software can recover the traversal path.
- Undefined:
  - path_bits is tied to 0.
  - No path registers are synthesised.
  - All other behaviour is identical.

Test Plan:
- Leaf root: node[5]={leaf=1,class=3}; start with root=5 → done at cycle 4, class_out=3, err=0, no mac_start.
- Two-level walk: node[0] thr=100, L=1, R=2; node[2] leaf class=9; acc=100 → mac_node=0, right chosen, class_out=9, path_bits[0]=1 (with EN).
- Left branch with slow MAC: node[0] thr=500; acc=499 returned 7 cycles after mac_start → fetches node 1, class from node 1, busy held throughout.
- Depth limit: node[4] internal with L=R=4, MAX_DEPTH=16 → exactly 16 mac_start pulses, then done=1, err=1, class_out unchanged from the previous walk.
- Reset mid-walk: assert rst while in WAIT_MAC, then drive acc_valid → no done, all outputs 0, IDLE; a following start walks normally.
- Ignored inputs: start pulsed during busy and stray acc_valid in IDLE → no effect on state, cur, or outputs.
